// File: rtl/asynchronous_fifo.sv
// asynchronous_fifo
// 16-entry x 8-bit FIFO demonstrator. An internal incrementing generator
// fills the FIFO whenever it is not full. Each rising edge of the slow,
// unrelated read_clk strobe pops one entry onto data_out. Every flop runs on
// write_clk; read_clk is only ever sampled as data through a synchronizer.
//
// Ports:
//   write_clk : the single clock, rising edge
//   reset     : asynchronous, active-high; clears all state
//   read_clk  : asynchronous read strobe; each rising edge requests one pop
//   data_out  : registered last-popped word
//   r_empty   : FIFO holds 0 entries
//   w_full    : FIFO holds 2**ADDR_WIDTH entries
`timescale 1ns/1ps
module asynchronous_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  write_clk,
  input  logic                  reset,
  input  logic                  read_clk,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  r_empty,
  output logic                  w_full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [DATA_WIDTH-1:0] gen;
  logic                  s1;
  logic                  s2;
  logic                  s3;
  logic                  rd_req;
  logic                  wr_en;
  logic                  rd_en;

  // Extra pointer MSB separates a full lap from an empty FIFO.
  assign r_empty = (wptr == rptr);
  assign w_full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                   (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

  // One request per strobe rise; a held-high level yields nothing more.
  assign rd_req = s2 & ~s3;

  // Both decisions use the flags from before the edge, so a pop from a
  // full FIFO blocks that cycle's write and the slot refills one cycle later.
  assign wr_en = ~w_full;
  assign rd_en = rd_req & ~r_empty;

  // s1/s2 resynchronize the strobe, s3 is history for edge detection.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= read_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Generator only advances on an accepted write, so no value is skipped
  // while the FIFO sits full.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      gen  <= '0;
    end else if (wr_en) begin
      wptr <= wptr + 1'b1;
      gen  <= gen + 1'b1;
    end
  end

  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= gen;
    end
  end

  // A request against an empty FIFO is dropped and data_out holds.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      rptr     <= '0;
      data_out <= '0;
    end else if (rd_en) begin
      rptr     <= rptr + 1'b1;
      data_out <= mem[rptr[ADDR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_asynchronous_fifo.sv
`timescale 1ns/1ps
module tb_asynchronous_fifo;

  logic       write_clk;
  logic       reset;
  logic       read_clk;
  logic [7:0] data_out;
  logic       r_empty;
  logic       w_full;

  int         tests;
  int         fails;
  logic [7:0] exp_next;
  logic [7:0] exp_q [$];
  logic [7:0] exp_val;

  asynchronous_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .write_clk (write_clk),
    .reset     (reset),
    .read_clk  (read_clk),
    .data_out  (data_out),
    .r_empty   (r_empty),
    .w_full    (w_full)
  );

  // 5 ns period, rising edges at 2.5, 7.5, 12.5, ...
  initial begin
    write_clk = 1'b0;
    forever #2.5 write_clk = ~write_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Expected pop value is queued at the moment a strobe rise is driven.
  task automatic push_expected();
    exp_q.push_back(exp_next);
    exp_next = exp_next + 8'd1;
  endtask

  task automatic test_nominal();
    // Absolute timing from t=0: reset released at 2 ns, read_clk rises at 25/75/125.
    #2 reset = 1'b0;
    #23 read_clk = 1'b1; push_expected();                   // 25
    #15;                                                     // 40
    exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests++; if (data_out !== exp_val) begin fails++;
      $display("FAIL nominal_pop0: data_out=%h expected %h", data_out, exp_val); end
    tests++; if (r_empty !== 1'b0) begin fails++;
      $display("FAIL nominal_empty: r_empty=%b expected 0", r_empty); end
    #10 read_clk = 1'b0;                                     // 50
    #25 read_clk = 1'b1; push_expected();                    // 75
    #5;                                                      // 80
    tests++; if (w_full !== 1'b0) begin fails++;
      $display("FAIL nominal_full_early: w_full=%b expected 0 at 80ns", w_full); end
    #5;                                                      // 85
    tests++; if (w_full !== 1'b1) begin fails++;
      $display("FAIL nominal_full: w_full=%b expected 1 at 85ns", w_full); end
    tests++; if (data_out !== 8'h00) begin fails++;
      $display("FAIL nominal_latency: data_out=%h expected 00 before 87.5ns", data_out); end
    #5;                                                      // 90
    exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests++; if (data_out !== exp_val) begin fails++;
      $display("FAIL nominal_pop1: data_out=%h expected %h", data_out, exp_val); end
    tests++; if (w_full !== 1'b0) begin fails++;
      $display("FAIL nominal_full_drop: w_full=%b expected 0 at 90ns", w_full); end
    #5;                                                      // 95
    tests++; if (w_full !== 1'b1) begin fails++;
      $display("FAIL nominal_full_refill: w_full=%b expected 1 at 95ns", w_full); end
    #5 read_clk = 1'b0;                                      // 100
    #25 read_clk = 1'b1; push_expected();                    // 125
    #15;                                                     // 140
    exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests++; if (data_out !== exp_val) begin fails++;
      $display("FAIL nominal_pop2: data_out=%h expected %h", data_out, exp_val); end
    #5 read_clk = 1'b0;                                      // 145 (a negedge)
  endtask

  task automatic test_reset();
    @(negedge write_clk);
    reset = 1'b1;
    repeat (4) @(negedge write_clk);
    tests++; if (data_out !== 8'h00 || r_empty !== 1'b1 || w_full !== 1'b0) begin fails++;
      $display("FAIL reset_hold: data_out=%h r_empty=%b w_full=%b expected 00 1 0",
               data_out, r_empty, w_full); end
    exp_q.delete();
    exp_next = 8'h00;
    reset = 1'b0;
    repeat (5) @(negedge write_clk);
    for (int k = 0; k < 2; k++) begin
      read_clk = 1'b1; push_expected();
      repeat (3) @(negedge write_clk);
      exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++; if (data_out !== exp_val) begin fails++;
        $display("FAIL reset_prepop%0d: data_out=%h expected %h", k, data_out, exp_val); end
      read_clk = 1'b0;
      repeat (3) @(negedge write_clk);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #1 reset = 1'b1;
    #0.5;
    tests++; if (data_out !== 8'h00 || r_empty !== 1'b1 || w_full !== 1'b0) begin fails++;
      $display("FAIL reset_async: data_out=%h r_empty=%b w_full=%b expected 00 1 0",
               data_out, r_empty, w_full); end
    exp_q.delete();
    exp_next = 8'h00;
    @(negedge write_clk);
  endtask

  task automatic test_fill();
    // Entered with reset high at a negedge, read_clk low.
    reset = 1'b0;
    tests++; if (r_empty !== 1'b1) begin fails++;
      $display("FAIL fill_empty_before: r_empty=%b expected 1", r_empty); end
    @(negedge write_clk);
    tests++; if (r_empty !== 1'b0) begin fails++;
      $display("FAIL fill_empty_after1: r_empty=%b expected 0", r_empty); end
    repeat (14) @(negedge write_clk);
    tests++; if (w_full !== 1'b0) begin fails++;
      $display("FAIL fill_full_after15: w_full=%b expected 0", w_full); end
    @(negedge write_clk);
    tests++; if (w_full !== 1'b1) begin fails++;
      $display("FAIL fill_full_after16: w_full=%b expected 1", w_full); end
    repeat (10) @(negedge write_clk);
    tests++; if (w_full !== 1'b1 || r_empty !== 1'b0) begin fails++;
      $display("FAIL fill_hold: w_full=%b r_empty=%b expected 1 0", w_full, r_empty); end
  endtask

  task automatic test_read_while_full();
    for (int k = 0; k < 3; k++) begin
      read_clk = 1'b1; push_expected();
      repeat (2) @(negedge write_clk);
      tests++; if (w_full !== 1'b1) begin fails++;
        $display("FAIL rwf_full_before%0d: w_full=%b expected 1", k, w_full); end
      @(negedge write_clk);
      exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++; if (data_out !== exp_val) begin fails++;
        $display("FAIL rwf_pop%0d: data_out=%h expected %h", k, data_out, exp_val); end
      tests++; if (w_full !== 1'b0 || r_empty !== 1'b0) begin fails++;
        $display("FAIL rwf_drop%0d: w_full=%b r_empty=%b expected 0 0", k, w_full, r_empty); end
      @(negedge write_clk);
      tests++; if (w_full !== 1'b1) begin fails++;
        $display("FAIL rwf_refill%0d: w_full=%b expected 1", k, w_full); end
      read_clk = 1'b0;
      repeat (3) @(negedge write_clk);
    end
  endtask

  task automatic test_hold_high();
    read_clk = 1'b1; push_expected();
    repeat (20) @(negedge write_clk);
    exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests++; if (data_out !== exp_val) begin fails++;
      $display("FAIL hold_single_pop: data_out=%h expected %h", data_out, exp_val); end
    tests++; if (w_full !== 1'b1) begin fails++;
      $display("FAIL hold_refilled: w_full=%b expected 1", w_full); end
    read_clk = 1'b0;
    repeat (3) @(negedge write_clk);
  endtask

  task automatic test_fast_toggle();
    for (int k = 0; k < 3; k++) begin
      // Glitch wholly between edges: never sampled, must not pop.
      #0.5 read_clk = 1'b1;
      #0.5 read_clk = 1'b0;
      // 2 ns pulse straddling one rising edge: sampled once, one pop.
      #0.5 read_clk = 1'b1; push_expected();
      #2   read_clk = 1'b0;
      @(negedge write_clk);
      repeat (3) @(negedge write_clk);
      exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++; if (data_out !== exp_val) begin fails++;
        $display("FAIL fast_pop%0d: data_out=%h expected %h", k, data_out, exp_val); end
      repeat (2) @(negedge write_clk);
    end
  endtask

  task automatic test_gen_wrap();
    logic [7:0] prev;
    logic       saw_wrap;
    int         bad;
    prev     = data_out;
    saw_wrap = 1'b0;
    bad      = 0;
    for (int k = 0; k < 257; k++) begin
      read_clk = 1'b1; push_expected();
      repeat (3) @(negedge write_clk);
      exp_val = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++; if (data_out !== exp_val) begin fails++; bad++;
        if (bad <= 5)
          $display("FAIL wrap_pop%0d: data_out=%h expected %h", k, data_out, exp_val); end
      if (prev == 8'hFF && data_out == 8'h00) saw_wrap = 1'b1;
      prev = data_out;
      read_clk = 1'b0;
      repeat (3) @(negedge write_clk);
    end
    tests++; if (saw_wrap !== 1'b1) begin fails++;
      $display("FAIL wrap_seen: saw FF->00 transition=%b expected 1", saw_wrap); end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    exp_next = 8'h00;
    reset    = 1'b1;
    read_clk = 1'b0;
    test_nominal();
    test_reset();
    test_fill();
    test_read_while_full();
    test_hold_high();
    test_fast_toggle();
    test_gen_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
